eth_bd_ram_access: RTL and testbench

Sequencing requester for the 256x32 single-port buffer-descriptor RAM (`eth_spram_256x32`). It arbitrates between the TX and RX descriptor engines and drives the RAM ce/we/oe/addr/di pins. Each read returns one complete 2-word descriptor: status word at address 2*idx, pointer word at 2*idx+1. Each write updates the status word with byte enables. It sits between the TX/RX BD state machines and the BD RAM instance.

---
 rtl/eth_bd_ram_access_if.sv | 56 +++++
 rtl/eth_bd_ram_access.sv | 221 ++++++++++++++++++++++
 tb/tb_eth_bd_ram_access.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_bd_ram_access_if.sv
// rtl/eth_bd_ram_access_if.sv - request, completion and BD RAM pin bundle for eth_bd_ram_access
// Purpose: carries the TX/RX descriptor request handshakes, the completion bus and the
//          single-port BD RAM pins between the BD engines, the requester and the RAM.
// Signals: tx_*/rx_*   request handshake + operation fields from each BD engine
//          rsp_*       one-cycle completion pulse with read data
//          ram_*       ce/we/oe/addr/di toward the RAM, dato back from it
// Modports: slave  = eth_bd_ram_access itself
//           master = the surrounding engines and RAM
interface eth_bd_ram_access_if;
   logic        tx_req;
   logic        tx_ready;
   logic [6:0]  tx_idx;
   logic        tx_wr;
   logic [3:0]  tx_be;
   logic [31:0] tx_wdata;

   logic        rx_req;
   logic        rx_ready;
   logic [6:0]  rx_idx;
   logic        rx_wr;
   logic [3:0]  rx_be;
   logic [31:0] rx_wdata;

   logic        rsp_valid;
   logic        rsp_src;
   logic        rsp_wr;
   logic [31:0] rsp_status;
   logic [31:0] rsp_ptr;

   logic        ram_ce;
   logic [3:0]  ram_we;
   logic        ram_oe;
   logic [7:0]  ram_addr;
   logic [31:0] ram_di;
   logic [31:0] ram_dato;

   modport slave (
      input  tx_req, tx_idx, tx_wr, tx_be, tx_wdata,
      output tx_ready,
      input  rx_req, rx_idx, rx_wr, rx_be, rx_wdata,
      output rx_ready,
      output rsp_valid, rsp_src, rsp_wr, rsp_status, rsp_ptr,
      output ram_ce, ram_we, ram_oe, ram_addr, ram_di,
      input  ram_dato
   );

   modport master (
      output tx_req, tx_idx, tx_wr, tx_be, tx_wdata,
      input  tx_ready,
      output rx_req, rx_idx, rx_wr, rx_be, rx_wdata,
      input  rx_ready,
      input  rsp_valid, rsp_src, rsp_wr, rsp_status, rsp_ptr,
      input  ram_ce, ram_we, ram_oe, ram_addr, ram_di,
      output ram_dato
   );
endinterface

// File: rtl/eth_bd_ram_access.sv
// rtl/eth_bd_ram_access.sv - TX/RX arbiter and access sequencer for the 256x32 BD RAM
// Purpose: grants one of the TX/RX descriptor engines at a time (round robin on ties),
//          reads a full descriptor (status at 2*idx, pointer at 2*idx+1) or writes the
//          status word with byte enables, and reports completion with a one-cycle pulse.
// Ports:   clk       rising-edge clock
//          rst       synchronous reset, active high
//          bus       eth_bd_ram_access_if.slave: tx_*/rx_* requests, rsp_* completion,
//                    ram_* pins toward the single-port BD RAM
// Params:  RX_FIRST  0 = TX wins the first tie after reset, 1 = RX wins it
module eth_bd_ram_access #(
   parameter bit RX_FIRST = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   eth_bd_ram_access_if.slave    bus
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD_S = 3'd1,
      RD_P = 3'd2,
      RD_E = 3'd3,
      WR   = 3'd4
   } state_t;

   state_t      state_q, state_d;

   // Last granted source: 1 = RX, 0 = TX. The other side wins the next tie.
   logic        last_rx_q, last_rx_d;

   // Latched operation fields of the granted request
   logic        src_q, src_d;
   logic [6:0]  idx_q, idx_d;
   logic        wr_q, wr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;

   // Status word is parked here so rsp_status only moves when the whole read completes
   logic [31:0] stat_tmp_q, stat_tmp_d;

   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_src_q, rsp_src_d;
   logic        rsp_wr_q, rsp_wr_d;
   logic [31:0] rsp_status_q, rsp_status_d;
   logic [31:0] rsp_ptr_q, rsp_ptr_d;

   logic        ram_ce_q, ram_ce_d;
   logic [3:0]  ram_we_q, ram_we_d;
   logic        ram_oe_q, ram_oe_d;
   logic [7:0]  ram_addr_q, ram_addr_d;
   logic [31:0] ram_di_q, ram_di_d;

   logic        tx_grant;
   logic        rx_grant;
   logic        ram_sample;

   // Read data is only trusted while this block itself enables the RAM output
   assign ram_sample = ram_oe_q & ram_ce_q;

   // Arbitration: grants are offered only in IDLE and never while reset is asserted
   always_comb begin
      tx_grant = 1'b0;
      rx_grant = 1'b0;
      if ((state_q == IDLE) && !rst) begin
         if (bus.tx_req && (!bus.rx_req || last_rx_q)) begin
            tx_grant = 1'b1;
         end else if (bus.rx_req) begin
            rx_grant = 1'b1;
         end
      end
   end

   assign bus.tx_ready = tx_grant;
   assign bus.rx_ready = rx_grant;

   // Next state, latched fields and completion bus
   always_comb begin
      state_d      = state_q;
      last_rx_d    = last_rx_q;
      src_d        = src_q;
      idx_d        = idx_q;
      wr_d         = wr_q;
      be_d         = be_q;
      wdata_d      = wdata_q;
      stat_tmp_d   = stat_tmp_q;
      rsp_valid_d  = 1'b0;
      rsp_src_d    = rsp_src_q;
      rsp_wr_d     = rsp_wr_q;
      rsp_status_d = rsp_status_q;
      rsp_ptr_d    = rsp_ptr_q;

      case (state_q)
         IDLE: begin
            if (tx_grant || rx_grant) begin
               src_d     = rx_grant;
               last_rx_d = rx_grant;
               idx_d     = rx_grant ? bus.rx_idx   : bus.tx_idx;
               wr_d      = rx_grant ? bus.rx_wr    : bus.tx_wr;
               be_d      = rx_grant ? bus.rx_be    : bus.tx_be;
               wdata_d   = rx_grant ? bus.rx_wdata : bus.tx_wdata;
               state_d   = wr_d ? WR : RD_S;
            end
         end
         RD_S: begin
            state_d = RD_P;
         end
         RD_P: begin
            // dato now holds the status word addressed during RD_S
            if (ram_sample) begin
               stat_tmp_d = bus.ram_dato;
            end
            state_d = RD_E;
         end
         RD_E: begin
            // dato now holds the pointer word addressed during RD_P
            if (ram_sample) begin
               rsp_status_d = stat_tmp_q;
               rsp_ptr_d    = bus.ram_dato;
            end
            rsp_valid_d = 1'b1;
            rsp_src_d   = src_q;
            rsp_wr_d    = 1'b0;
            state_d     = IDLE;
         end
         WR: begin
            rsp_valid_d = 1'b1;
            rsp_src_d   = src_q;
            rsp_wr_d    = 1'b1;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // RAM pins for the coming cycle are decoded from the next state, so the
   // registered outputs line up with the state they belong to.
   always_comb begin
      ram_ce_d   = 1'b0;
      ram_we_d   = 4'b0000;
      ram_oe_d   = 1'b0;
      ram_addr_d = ram_addr_q;
      ram_di_d   = ram_di_q;

      case (state_d)
         RD_S: begin
            ram_ce_d   = 1'b1;
            ram_addr_d = {idx_d, 1'b0};
         end
         RD_P, RD_E: begin
            ram_ce_d   = 1'b1;
            ram_oe_d   = 1'b1;
            ram_addr_d = {idx_d, 1'b1};
         end
         WR: begin
            ram_ce_d   = 1'b1;
            ram_we_d   = be_d;
            ram_addr_d = {idx_d, 1'b0};
            ram_di_d   = wdata_d;
         end
         default: begin
            ram_ce_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_rx_q    <= ~RX_FIRST;
         src_q        <= 1'b0;
         idx_q        <= 7'd0;
         wr_q         <= 1'b0;
         be_q         <= 4'b0000;
         wdata_q      <= 32'd0;
         stat_tmp_q   <= 32'd0;
         rsp_valid_q  <= 1'b0;
         rsp_src_q    <= 1'b0;
         rsp_wr_q     <= 1'b0;
         rsp_status_q <= 32'd0;
         rsp_ptr_q    <= 32'd0;
         ram_ce_q     <= 1'b0;
         ram_we_q     <= 4'b0000;
         ram_oe_q     <= 1'b0;
         ram_addr_q   <= 8'd0;
         ram_di_q     <= 32'd0;
      end else begin
         state_q      <= state_d;
         last_rx_q    <= last_rx_d;
         src_q        <= src_d;
         idx_q        <= idx_d;
         wr_q         <= wr_d;
         be_q         <= be_d;
         wdata_q      <= wdata_d;
         stat_tmp_q   <= stat_tmp_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_src_q    <= rsp_src_d;
         rsp_wr_q     <= rsp_wr_d;
         rsp_status_q <= rsp_status_d;
         rsp_ptr_q    <= rsp_ptr_d;
         ram_ce_q     <= ram_ce_d;
         ram_we_q     <= ram_we_d;
         ram_oe_q     <= ram_oe_d;
         ram_addr_q   <= ram_addr_d;
         ram_di_q     <= ram_di_d;
      end
   end

   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_src    = rsp_src_q;
   assign bus.rsp_wr     = rsp_wr_q;
   assign bus.rsp_status = rsp_status_q;
   assign bus.rsp_ptr    = rsp_ptr_q;
   assign bus.ram_ce     = ram_ce_q;
   assign bus.ram_we     = ram_we_q;
   assign bus.ram_oe     = ram_oe_q;
   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_di     = ram_di_q;

endmodule

// File: tb/tb_eth_bd_ram_access.sv
// tb/tb_eth_bd_ram_access.sv - scoreboard bench for eth_bd_ram_access with a BD RAM model
module tb_eth_bd_ram_access;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   eth_bd_ram_access_if bus();

   eth_bd_ram_access #(.RX_FIRST(1'b0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, req);
      end
   endtask

   function automatic logic [31:0] init_word(input int a);
      case (a)
         10:      init_word = 32'h0000_6000;
         11:      init_word = 32'h1234_5678;
         254:     init_word = 32'hFFFF_FFFF;
         default: init_word = (32'(a) * 32'h0100_0193) ^ 32'hC3A5_0F1E;
      endcase
   endfunction

   // Single-port 256x32 RAM: one-cycle read latency, byte writes, output only when enabled
   logic [31:0] ram_mem [256];
   logic [31:0] ram_dout;
   bit          ram_init = 1'b0;

   always @(posedge clk) begin
      if (!ram_init) begin
         for (int a = 0; a < 256; a++) ram_mem[a] = init_word(a);
         ram_init = 1'b1;
      end
      if (bus.ram_ce) begin
         ram_dout <= ram_mem[bus.ram_addr];
         for (int b = 0; b < 4; b++)
            if (bus.ram_we[b]) ram_mem[bus.ram_addr][8*b +: 8] = bus.ram_di[8*b +: 8];
      end
   end

   // A garbage pattern stands in for the floating bus so a stray capture is visible
   assign bus.ram_dato = (bus.ram_oe && bus.ram_ce) ? ram_dout : (32'hBAD0_0000 ^ 32'(cyc));

   typedef struct {
      bit          src;
      bit          wr;
      logic [31:0] st;
      logic [31:0] ptr;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: descriptor memory, round-robin memory, busy-until cycle
   logic [31:0] ref_mem [256];
   bit          ref_init    = 1'b0;
   bit          ref_last_rx = 1'b1;
   int          next_free   = 0;
   bit          cur_valid   = 1'b0;
   int          cur_acc     = 0;
   bit          cur_wr      = 1'b0;
   logic [6:0]  cur_idx     = 7'd0;
   logic [3:0]  cur_be      = 4'd0;
   logic [31:0] cur_wd      = 32'd0;
   bit          rst_prev    = 1'b0;
   int          tx_acc_cnt  = 0;
   int          rx_acc_cnt  = 0;
   int          tx_wait     = 0;
   int          rx_wait     = 0;

   // Stimulus-side tracker: checks grants and RAM pins, pushes expected responses
   always @(negedge clk) begin : trk
      int          k;
      bit          idle;
      bit          etx, erx, s;
      logic [6:0]  idx;
      logic [3:0]  be;
      logic [31:0] wd;
      exp_t        e;
      if (!ref_init) begin
         for (int a = 0; a < 256; a++) ref_mem[a] = init_word(a);
         ref_init = 1'b1;
      end

      if (rst_prev)
         chk("reset_outputs", {bus.ram_ce, bus.ram_oe, bus.ram_we, bus.ram_addr, bus.rsp_valid}, 64'd0);

      k = cyc - cur_acc;
      if (cur_valid && !cur_wr && k >= 1 && k <= 3) begin
         chk("read_pins", {bus.ram_ce, bus.ram_oe, bus.ram_we, bus.ram_addr},
             {1'b1, (k != 1), 4'b0000, cur_idx, (k != 1)});
      end else if (cur_valid && cur_wr && k == 1) begin
         chk("write_pins", {bus.ram_ce, bus.ram_oe, bus.ram_we, bus.ram_addr},
             {1'b1, 1'b0, cur_be, cur_idx, 1'b0});
         chk("write_data", bus.ram_di, cur_wd);
      end else begin
         chk("idle_pins", {bus.ram_ce, bus.ram_oe, bus.ram_we}, 64'd0);
      end
      chk("oe_with_we", bus.ram_oe && (bus.ram_we != 4'b0000), 64'd0);

      idle = !rst && (cyc >= next_free);
      etx  = idle && bus.tx_req && (!bus.rx_req || ref_last_rx);
      erx  = idle && bus.rx_req && (!bus.tx_req || !ref_last_rx);
      chk("ready_pair", {bus.tx_ready, bus.rx_ready}, {etx, erx});

      if ((bus.tx_req && bus.tx_ready) || (bus.rx_req && bus.rx_ready)) begin
         s   = !(bus.tx_req && bus.tx_ready);
         idx = s ? bus.rx_idx   : bus.tx_idx;
         be  = s ? bus.rx_be    : bus.tx_be;
         wd  = s ? bus.rx_wdata : bus.tx_wdata;
         e.src = s;
         e.wr  = s ? bus.rx_wr : bus.tx_wr;
         if (e.wr) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) ref_mem[{idx, 1'b0}][8*b +: 8] = wd[8*b +: 8];
            e.st  = 32'd0;
            e.ptr = 32'd0;
            e.cyc = cyc + 2;
         end else begin
            e.st  = ref_mem[{idx, 1'b0}];
            e.ptr = ref_mem[{idx, 1'b1}];
            e.cyc = cyc + 4;
         end
         exp_q.push_back(e);
         next_free   = e.cyc;
         ref_last_rx = s;
         cur_valid   = 1'b1;
         cur_acc     = cyc;
         cur_wr      = e.wr;
         cur_idx     = idx;
         cur_be      = be;
         cur_wd      = wd;
         if (s) rx_acc_cnt++; else tx_acc_cnt++;
      end

      tx_wait = (bus.tx_req && !bus.tx_ready) ? tx_wait + 1 : 0;
      rx_wait = (bus.rx_req && !bus.rx_ready) ? rx_wait + 1 : 0;
      chk("no_starvation", (tx_wait > 40) || (rx_wait > 40), 64'd0);

      if (rst) begin
         next_free   = cyc + 1;
         ref_last_rx = 1'b1;
         cur_valid   = 1'b0;
      end
      rst_prev = rst;
   end

   // Response monitor: pops the scoreboard whenever the DUT completes something
   logic [31:0] hold_st  = 32'd0;
   logic [31:0] hold_ptr = 32'd0;

   always @(negedge clk) begin : mon
      exp_t e;
      if (bus.rsp_valid) begin
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
            chk("rsp_src_wr", {bus.rsp_src, bus.rsp_wr}, {e.src, e.wr});
            if (!e.wr) begin
               hold_st  = e.st;
               hold_ptr = e.ptr;
            end
         end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
         e = exp_q.pop_front();
         chk("rsp_missing", 64'd0, 64'd1);
      end
      chk("rsp_data", {bus.rsp_status, bus.rsp_ptr}, {hold_st, hold_ptr});
      if (rst) begin
         exp_q.delete();
         hold_st  = 32'd0;
         hold_ptr = 32'd0;
      end
   end

   task automatic set_req(input bit s, input bit req, input logic [6:0] idx, input bit wr,
                          input logic [3:0] be, input logic [31:0] wd);
      if (!s) begin
         bus.tx_req = req; bus.tx_idx = idx; bus.tx_wr = wr; bus.tx_be = be; bus.tx_wdata = wd;
      end else begin
         bus.rx_req = req; bus.rx_idx = idx; bus.rx_wr = wr; bus.rx_be = be; bus.rx_wdata = wd;
      end
   endtask

   task automatic issue(input bit s, input logic [6:0] idx, input bit wr,
                        input logic [3:0] be, input logic [31:0] wd);
      int start;
      int n;
      start = s ? rx_acc_cnt : tx_acc_cnt;
      set_req(s, 1'b1, idx, wr, be, wd);
      n = 0;
      while ((s ? rx_acc_cnt : tx_acc_cnt) == start && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      set_req(s, 1'b0, idx, wr, be, wd);
   endtask

   task automatic rand_op(input bit s, input int p_req);
      logic [6:0] idx;
      case ($urandom_range(3))
         0:       idx = 7'd0;
         1:       idx = 7'd127;
         default: idx = 7'($urandom_range(127));
      endcase
      set_req(s, ($urandom_range(99) < 32'(p_req)), idx, 1'($urandom_range(1)),
              4'($urandom_range(15)), $urandom);
   endtask

   task automatic both_random(input int ncyc, input int p_req);
      int tl;
      int rl;
      tl = tx_acc_cnt;
      rl = rx_acc_cnt;
      for (int i = 0; i < ncyc; i++) begin
         if (!bus.tx_req || tx_acc_cnt != tl) begin tl = tx_acc_cnt; rand_op(1'b0, p_req); end
         if (!bus.rx_req || rx_acc_cnt != rl) begin rl = rx_acc_cnt; rand_op(1'b1, p_req); end
         @(posedge clk); #1;
      end
      bus.tx_req = 1'b0;
      bus.rx_req = 1'b0;
      repeat (6) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      set_req(1'b0, 1'b0, 7'd0, 1'b0, 4'd0, 32'd0);
      set_req(1'b1, 1'b0, 7'd0, 1'b0, 4'd0, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      issue(1'b0, 7'd5, 1'b0, 4'b0000, 32'd0);
      issue(1'b1, 7'd127, 1'b1, 4'b0011, 32'hAAAA_5555);
      issue(1'b1, 7'd127, 1'b0, 4'b0000, 32'd0);
      issue(1'b0, 7'd9, 1'b0, 4'b0000, 32'd0);
      issue(1'b0, 7'd9, 1'b1, 4'b1111, $urandom);
      issue(1'b0, 7'd9, 1'b0, 4'b0000, 32'd0);
      issue(1'b0, 7'd3, 1'b1, 4'b0000, 32'hDEAD_BEEF);
      issue(1'b0, 7'd3, 1'b0, 4'b0000, 32'd0);
      issue(1'b1, 7'd0, 1'b1, 4'b1100, $urandom);
      issue(1'b0, 7'd0, 1'b0, 4'b0000, 32'd0);
      repeat (6) @(posedge clk);
      #1;

      both_random(300, 70);

      // Reset while the read sits in RD_P
      issue(1'b0, 7'd20, 1'b0, 4'b0000, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      issue(1'b0, 7'd20, 1'b0, 4'b0000, 32'd0);
      repeat (6) @(posedge clk);
      #1;

      // Both engines requesting non-stop straight out of reset
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      both_random(60, 100);

      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog");
   end

endmodule
